// File: rtl/otbn_hw_loop_ctrl_if.sv
// rtl/otbn_hw_loop_ctrl_if.sv - Instruction, loop-stack and prefetch signals of the OTBN loop controller
// Optional: OTBN_LOOP_PERF_CNT_EN adds loop_jump_cnt_o.
interface otbn_hw_loop_ctrl_if #(
  parameter int ImemSizeByte   = 4096,
  parameter int LoopStackDepth = 8
);
  localparam int ImemAddrWidth = (ImemSizeByte > 1) ? $clog2(ImemSizeByte) : 1;
  localparam int DepthWidth    = $clog2(LoopStackDepth + 1);

  logic                     state_reset_i;
  logic                     insn_valid_i;
  logic                     insn_stall_i;
  logic [ImemAddrWidth-1:0] insn_addr_i;
  logic                     insn_branch_i;
  logic                     loop_start_i;
  logic [11:0]              loop_bodysize_i;
  logic [31:0]              loop_iterations_i;

  logic                     loop_jump_o;
  logic [ImemAddrWidth-1:0] loop_jump_addr_o;
  logic                     loop_err_o;
  logic [DepthWidth-1:0]    loop_depth_o;
  logic                     prefetch_loop_active_o;
  logic [31:0]              prefetch_loop_iterations_o;
  logic [ImemAddrWidth:0]   prefetch_loop_end_addr_o;
  logic [ImemAddrWidth-1:0] prefetch_loop_jump_addr_o;
`ifdef OTBN_LOOP_PERF_CNT_EN
  logic [31:0]              loop_jump_cnt_o;
`endif

  modport master (
    output state_reset_i, insn_valid_i, insn_stall_i, insn_addr_i, insn_branch_i,
    output loop_start_i, loop_bodysize_i, loop_iterations_i,
`ifdef OTBN_LOOP_PERF_CNT_EN
    input  loop_jump_cnt_o,
`endif
    input  loop_jump_o, loop_jump_addr_o, loop_err_o, loop_depth_o,
    input  prefetch_loop_active_o, prefetch_loop_iterations_o,
    input  prefetch_loop_end_addr_o, prefetch_loop_jump_addr_o
  );

  modport slave (
    input  state_reset_i, insn_valid_i, insn_stall_i, insn_addr_i, insn_branch_i,
    input  loop_start_i, loop_bodysize_i, loop_iterations_i,
`ifdef OTBN_LOOP_PERF_CNT_EN
    output loop_jump_cnt_o,
`endif
    output loop_jump_o, loop_jump_addr_o, loop_err_o, loop_depth_o,
    output prefetch_loop_active_o, prefetch_loop_iterations_o,
    output prefetch_loop_end_addr_o, prefetch_loop_jump_addr_o
  );
endinterface

// File: rtl/otbn_hw_loop_ctrl.sv
// rtl/otbn_hw_loop_ctrl.sv - OTBN hardware loop stack issuing loop-back jumps and prefetch hints
// Optional: OTBN_LOOP_PERF_CNT_EN adds a saturating count of issued loop jumps.
module otbn_hw_loop_ctrl #(
  parameter int ImemSizeByte   = 4096,
  parameter int LoopStackDepth = 8
) (
  input logic                clk_i,
  input logic                rst_ni,
  otbn_hw_loop_ctrl_if.slave bus
);
  localparam int AW         = (ImemSizeByte > 1) ? $clog2(ImemSizeByte) : 1;
  localparam int DepthWidth = $clog2(LoopStackDepth + 1);
  localparam int IdxWidth   = (LoopStackDepth > 1) ? $clog2(LoopStackDepth) : 1;
  localparam int EndWidth   = AW + 15;

  logic [DepthWidth-1:0] r_depth;
  logic [AW-1:0]         r_start [LoopStackDepth];
  logic [AW:0]           r_end   [LoopStackDepth];
  logic [31:0]           r_iter  [LoopStackDepth];

  logic                  w_retire;
  logic                  w_full;
  logic                  w_at_end;
  logic                  w_err_start;
  logic                  w_err_end;
  logic                  w_push;
  logic                  w_jump;
  logic                  w_pop;
  logic [IdxWidth-1:0]   w_top_idx;
  logic [IdxWidth-1:0]   w_push_idx;
  logic [EndWidth-1:0]   w_end_full;
  logic [AW-1:0]         w_new_start;

  assign w_retire    = bus.insn_valid_i & ~bus.insn_stall_i;
  assign w_top_idx   = (r_depth == '0) ? '0 : IdxWidth'(r_depth - 1'b1);
  assign w_push_idx  = IdxWidth'(r_depth);
  assign w_full      = (r_depth == DepthWidth'(LoopStackDepth));
  // Wide enough that a large body size can never wrap back into IMEM range.
  assign w_end_full  = EndWidth'(bus.insn_addr_i) + EndWidth'({bus.loop_bodysize_i, 2'b00});
  assign w_new_start = bus.insn_addr_i + AW'(4);

  assign w_at_end    = w_retire & (r_depth != '0) &
                       ({1'b0, bus.insn_addr_i} == r_end[w_top_idx]);
  assign w_err_end   = w_at_end & (bus.loop_start_i | bus.insn_branch_i);
  assign w_err_start = w_retire & bus.loop_start_i &
                       ((bus.loop_iterations_i == '0) | (bus.loop_bodysize_i == '0) | w_full |
                        (w_end_full >= EndWidth'(ImemSizeByte)));

  assign w_push = w_retire & bus.loop_start_i & ~w_err_start & ~w_err_end & ~bus.state_reset_i;
  assign w_jump = w_at_end & ~w_err_end & (r_iter[w_top_idx] > 32'd1) & ~bus.state_reset_i;
  assign w_pop  = w_at_end & ~w_err_end & ~(r_iter[w_top_idx] > 32'd1) & ~bus.state_reset_i;

  assign bus.loop_jump_o      = w_jump;
  assign bus.loop_jump_addr_o = r_start[w_top_idx];
  assign bus.loop_err_o       = (w_err_start | w_err_end) & ~bus.state_reset_i;
  assign bus.loop_depth_o     = r_depth;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_depth <= '0;
      for (int i = 0; i < LoopStackDepth; i++) begin
        r_start[i] <= '0;
        r_end[i]   <= '0;
        r_iter[i]  <= '0;
      end
    end else if (bus.state_reset_i) begin
      r_depth <= '0;
      for (int i = 0; i < LoopStackDepth; i++) begin
        r_start[i] <= '0;
        r_end[i]   <= '0;
        r_iter[i]  <= '0;
      end
    end else if (w_push) begin
      r_start[w_push_idx] <= w_new_start;
      r_end[w_push_idx]   <= w_end_full[AW:0];
      r_iter[w_push_idx]  <= bus.loop_iterations_i;
      r_depth             <= r_depth + 1'b1;
    end else if (w_jump) begin
      r_iter[w_top_idx] <= r_iter[w_top_idx] - 32'd1;
    end else if (w_pop) begin
      r_depth <= r_depth - 1'b1;
    end
  end

  // A freshly pushed entry is forwarded so a 1-instruction body prefetches its start.
  always_comb begin
    bus.prefetch_loop_active_o     = 1'b0;
    bus.prefetch_loop_iterations_o = '0;
    bus.prefetch_loop_end_addr_o   = '0;
    bus.prefetch_loop_jump_addr_o  = '0;
    if (w_push) begin
      bus.prefetch_loop_active_o     = 1'b1;
      bus.prefetch_loop_iterations_o = bus.loop_iterations_i;
      bus.prefetch_loop_end_addr_o   = w_end_full[AW:0];
      bus.prefetch_loop_jump_addr_o  = w_new_start;
    end else if (r_depth != '0) begin
      bus.prefetch_loop_active_o     = 1'b1;
      bus.prefetch_loop_iterations_o = r_iter[w_top_idx];
      bus.prefetch_loop_end_addr_o   = r_end[w_top_idx];
      bus.prefetch_loop_jump_addr_o  = r_start[w_top_idx];
    end
  end

`ifdef OTBN_LOOP_PERF_CNT_EN
  logic [31:0] r_jump_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_jump_cnt <= '0;
    end else if (bus.state_reset_i) begin
      r_jump_cnt <= '0;
    end else if (w_jump && (r_jump_cnt != 32'hFFFF_FFFF)) begin
      r_jump_cnt <= r_jump_cnt + 32'd1;
    end
  end

  assign bus.loop_jump_cnt_o = r_jump_cnt;
`endif
endmodule

// File: tb/tb_otbn_hw_loop_ctrl.sv
// tb/tb_otbn_hw_loop_ctrl.sv - Scoreboard bench for otbn_hw_loop_ctrl against a queue-based loop stack model
// Optional: OTBN_LOOP_PERF_CNT_EN also checks loop_jump_cnt_o.
module tb_otbn_hw_loop_ctrl;
  localparam int IMEM  = 4096;
  localparam int DEPTH = 8;

  typedef struct {
    bit [11:0] s;
    bit [12:0] e;
    bit [31:0] it;
  } ent_t;

  typedef struct {
    bit        jump;
    bit [11:0] jaddr;
    bit        err;
    bit [3:0]  depth;
    bit        pact;
    bit [31:0] piter;
    bit [12:0] pend;
    bit [11:0] pjaddr;
    bit [31:0] cnt;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  otbn_hw_loop_ctrl_if #(.ImemSizeByte(IMEM), .LoopStackDepth(DEPTH)) bus ();

  otbn_hw_loop_ctrl #(.ImemSizeByte(IMEM), .LoopStackDepth(DEPTH)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  ent_t      stk[$];
  exp_t      exp_q[$];
  bit [31:0] m_cnt = 0;
  int        n_checks = 0;
  int        n_errors = 0;
  bit        last_jump;
  bit        last_retire;
  bit [11:0] last_start;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus; the model derives the expected outputs and then advances.
  task automatic step(input bit rst, input bit v, input bit st, input int addr, input bit br,
                      input bit ls, input int body, input bit [31:0] iters, input bit sr);
    exp_t e;
    ent_t t;
    bit   retire, at_end, err_end, err_start, push;
    int   end_new;
    @(posedge clk_i);
    #1;
    if (!rst) begin
      v = 0; ls = 0; sr = 0; br = 0;
      stk.delete();
      m_cnt = 0;
    end
    rst_ni                = rst;
    bus.insn_valid_i      = v;
    bus.insn_stall_i      = st;
    bus.insn_addr_i       = addr[11:0];
    bus.insn_branch_i     = br;
    bus.loop_start_i      = ls;
    bus.loop_bodysize_i   = body[11:0];
    bus.loop_iterations_i = iters;
    bus.state_reset_i     = sr;

    t = '{default: 0};
    if (stk.size() > 0) t = stk[stk.size()-1];
    retire    = v && !st;
    at_end    = retire && (stk.size() > 0) && (addr == int'(t.e));
    end_new   = addr + 4 * body;
    err_end   = at_end && (ls || br);
    err_start = retire && ls && (iters == 0 || body == 0 || stk.size() == DEPTH || end_new >= IMEM);
    push      = retire && ls && !err_end && !err_start && !sr;

    e = '{default: 0};
    e.err   = !sr && (err_end || err_start);
    e.jump  = !sr && at_end && !err_end && (t.it > 1);
    e.jaddr = t.s;
    e.depth = 4'(stk.size());
    e.cnt   = m_cnt;
    if (push) begin
      e.pact = 1; e.piter = iters; e.pend = end_new[12:0]; e.pjaddr = 12'((addr + 4) % IMEM);
    end else if (stk.size() > 0) begin
      e.pact = 1; e.piter = t.it; e.pend = t.e; e.pjaddr = t.s;
    end
    exp_q.push_back(e);

    if (sr) begin
      stk.delete();
      m_cnt = 0;
    end else if (push) begin
      stk.push_back('{s: 12'((addr + 4) % IMEM), e: end_new[12:0], it: iters});
    end else if (e.jump) begin
      t.it = t.it - 1;
      stk[stk.size()-1] = t;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else if (at_end && !err_end) begin
      void'(stk.pop_back());
    end
    last_jump   = e.jump;
    last_retire = retire;
    last_start  = t.s;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ins(input int addr);
    step(1, 1, 0, addr, 0, 0, 0, 0, 0);
  endtask

  task automatic lp(input int addr, input int body, input bit [31:0] it);
    step(1, 1, 0, addr, 0, 1, body, it, 0);
  endtask

  task automatic run(input int start_pc, input int n);
    int pc;
    pc = start_pc;
    for (int i = 0; i < n; i++) begin
      ins(pc);
      pc = last_jump ? int'(last_start) : (pc + 4) % IMEM;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("loop_jump", bus.loop_jump_o, e.jump);
        if (e.jump) chk("loop_jump_addr", bus.loop_jump_addr_o, e.jaddr);
        chk("loop_err", bus.loop_err_o, e.err);
        chk("loop_depth", bus.loop_depth_o, e.depth);
        chk("pf_active", bus.prefetch_loop_active_o, e.pact);
        chk("pf_iterations", bus.prefetch_loop_iterations_o, e.piter);
        chk("pf_end_addr", bus.prefetch_loop_end_addr_o, e.pend);
        chk("pf_jump_addr", bus.prefetch_loop_jump_addr_o, e.pjaddr);
`ifdef OTBN_LOOP_PERF_CNT_EN
        chk("jump_cnt", bus.loop_jump_cnt_o, e.cnt);
`endif
      end
    end
  end

  initial begin : stimulus
    int pc;
    bit rst, v, st, br, ls, sr;
    int body;
    bit [31:0] it;

    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // LOOPI 0x100 with three iterations, then a 1-instruction body
    lp(32'h100, 3, 3);
    run(32'h104, 10);
    lp(32'h200, 1, 4);
    run(32'h204, 5);

    // Overflow on the ninth nested loop, zero iterations/body size
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) lp(32'h300 + 4 * i, 200, 2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    lp(32'h100, 3, 0);
    lp(32'h100, 0, 3);
    lp(32'hFF0, 4, 2);

    // Branch and stall at the loop end, then a normal retire there
    lp(32'h100, 3, 2);
    ins(32'h104); ins(32'h108);
    step(1, 1, 0, 32'h10C, 1, 0, 0, 0, 0);
    step(1, 1, 1, 32'h10C, 0, 0, 0, 0, 0);
    step(1, 1, 0, 32'h10C, 0, 1, 2, 2, 0);
    run(32'h10C, 5);

    // Three loops sharing an end; state_reset on that end, then a normal run
    lp(32'h400, 4, 2); lp(32'h404, 3, 2); lp(32'h408, 2, 3);
    ins(32'h40C);
    step(1, 1, 0, 32'h410, 0, 0, 0, 0, 1);
    idle();
    lp(32'h400, 4, 2); lp(32'h404, 3, 2); lp(32'h408, 2, 3);
    run(32'h40C, 30);

    // Asynchronous reset in the middle of a loop
    lp(32'h600, 2, 5);
    ins(32'h604);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Two-level loop: 4 inner jumps per outer pass plus 2 outer jumps
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    lp(32'h500, 3, 3);
    for (int o = 0; o < 3; o++) begin
      lp(32'h504, 1, 5);
      run(32'h508, 5);
      ins(32'h50C);
    end
    idle();
`ifdef OTBN_LOOP_PERF_CNT_EN
    chk("jump_cnt_nested_total", bus.loop_jump_cnt_o, 14);
`endif

    pc = 0;
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom % 400) != 0;
      v    = ($urandom % 10) != 0;
      st   = ($urandom % 7) == 0;
      ls   = ($urandom % 10) == 0;
      br   = ($urandom % 20) == 0;
      sr   = ($urandom % 150) == 0;
      body = $urandom_range(0, 5);
      it   = (($urandom % 8) == 0) ? 32'd0 : $urandom_range(1, 4);
      if (($urandom % 40) == 0) pc = $urandom_range(0, 1023) * 4;
      step(rst, v, st, pc, br, ls, body, it, sr);
      if (last_retire) pc = last_jump ? int'(last_start) : (pc + 4) % IMEM;
    end
    idle();

    repeat (3) @(posedge clk_i);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
